// File: rtl/wdog_ctrl_if.sv
// Register bus between a host (master) and the watchdog controller (slave).
// One write per cycle; rdata is a combinational read of addr.
interface wdog_ctrl_if;
    logic        write;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output write, output addr, output wdata, input  rdata);
    modport slave  (input  write, input  addr, input  wdata, output rdata);
endinterface

// File: rtl/wdog_ctrl.sv
// Watchdog controller: lock-protected config/kick registers and the
// IDLE/RUN/WARN/FIRE sequencer that drives the warning IRQ, the timer enable
// and a fixed-width watchdog reset pulse.
// Optional feature: define WDOG_WINDOW_EN to add the WINDOW register at
// address 7; kicks while COUNT > WINDOW are treated as early and fire.
module wdog_ctrl #(
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned PRESCALE      = 1,
    parameter int unsigned RST_PULSE_LEN = 16,
    parameter logic [31:0] KICK_KEY      = 32'h5A5AA5A5,
    parameter logic [31:0] UNLOCK_KEY    = 32'h1ACCE551
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    wdog_ctrl_if.slave s_bus,
    input  logic       i_kick,
    output logic       o_wdog_irq,
    output logic       o_wdog_rst,
    output logic       o_timer_en
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned RW = (RST_PULSE_LEN > 1) ? $clog2(RST_PULSE_LEN) : 1;

    localparam logic [3:0] A_CTRL   = 4'd0;
    localparam logic [3:0] A_LOAD   = 4'd1;
    localparam logic [3:0] A_WARN   = 4'd2;
    localparam logic [3:0] A_KICK   = 4'd3;
    localparam logic [3:0] A_LOCK   = 4'd4;
    localparam logic [3:0] A_COUNT  = 4'd5;
    localparam logic [3:0] A_STATUS = 4'd6;
`ifdef WDOG_WINDOW_EN
    localparam logic [3:0] A_WINDOW = 4'd7;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WARN = 2'd2,
        ST_FIRE = 2'd3
    } state_t;

    // Saturating decrement: the counter never wraps below zero.
    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    state_t            r_state;
    logic [1:0]        r_ctrl;
    logic [CNT_W-1:0]  r_load;
    logic [CNT_W-1:0]  r_warn;
    logic [CNT_W-1:0]  r_count;
    logic [PW-1:0]     r_presc;
    logic [RW-1:0]     r_rst_cnt;
    logic              r_unlocked;
    logic              r_fired;
    logic              r_irq;
    logic              r_rst_out;
    logic              r_timer_en;
`ifdef WDOG_WINDOW_EN
    logic [CNT_W-1:0]  r_window;
`endif

    logic              w_ctrl_acc;
    logic              w_kick_wr;
    logic              w_key_ok;
    logic              w_key_bad;
    logic              w_kick;
    logic              w_early;
    logic              w_tick;
    logic              w_expire;
    logic              w_fire;
    logic              w_stat_clr;
    logic              w_irq_en_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [PW-1:0]     w_presc_nxt;
    logic [CNT_W-1:0]  w_wdata_cnt;
    logic [31:0]       w_rdata;

    // CTRL writes are accepted only while unlocked and never during FIRE.
    assign w_ctrl_acc   = s_bus.write && (s_bus.addr == A_CTRL) && r_unlocked
                          && (r_state != ST_FIRE);
    assign w_kick_wr    = s_bus.write && (s_bus.addr == A_KICK);
    assign w_key_ok     = w_kick_wr && (s_bus.wdata == KICK_KEY);
    assign w_key_bad    = w_kick_wr && (s_bus.wdata != KICK_KEY);
    assign w_kick       = i_kick || w_key_ok;
    assign w_stat_clr   = s_bus.write && (s_bus.addr == A_STATUS) && s_bus.wdata[2];
    assign w_irq_en_nxt = w_ctrl_acc ? s_bus.wdata[1] : r_ctrl[1];
    assign w_wdata_cnt  = s_bus.wdata[CNT_W-1:0];

`ifdef WDOG_WINDOW_EN
    assign w_early = (r_count > r_window);
`else
    assign w_early = 1'b0;
`endif

    // Prescaler terminal count marks the cycle on which COUNT steps down.
    assign w_tick      = (r_presc == PW'(PRESCALE - 1));
    assign w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
    assign w_cnt_nxt   = w_tick ? sat_dec(r_count) : r_count;
    assign w_expire    = w_tick && (r_count == CNT_W'(1));

    // A bad key beats a simultaneous pin kick; a legal kick beats expiry.
    assign w_fire = w_key_bad || (w_kick && w_early) || (!w_kick && w_expire);

    // Combinational register read; unmapped and write-only addresses read 0.
    always_comb begin
        w_rdata = '0;
        case (s_bus.addr)
            A_CTRL:   w_rdata = {30'd0, r_ctrl};
            A_LOAD:   w_rdata = 32'(r_load);
            A_WARN:   w_rdata = 32'(r_warn);
            A_COUNT:  w_rdata = 32'(r_count);
            A_STATUS: w_rdata = {28'd0, r_unlocked, r_fired, r_state};
`ifdef WDOG_WINDOW_EN
            A_WINDOW: w_rdata = 32'(r_window);
`endif
            default:  w_rdata = '0;
        endcase
    end

    assign s_bus.rdata = w_rdata;

    // Lock and configuration registers; every config write made while unlocked closes the lock.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_unlocked <= 1'b0;
            r_load     <= '1;
            r_warn     <= '0;
`ifdef WDOG_WINDOW_EN
            r_window   <= '1;
`endif
        end else if (s_bus.write) begin
            case (s_bus.addr)
                A_LOCK: r_unlocked <= (s_bus.wdata == UNLOCK_KEY);
                A_CTRL: r_unlocked <= 1'b0;
                A_LOAD: begin
                    if (r_unlocked) begin
                        if (w_wdata_cnt != '0) begin
                            r_load <= w_wdata_cnt;
                        end
                        r_unlocked <= 1'b0;
                    end
                end
                A_WARN: begin
                    if (r_unlocked) begin
                        r_warn     <= w_wdata_cnt;
                        r_unlocked <= 1'b0;
                    end
                end
`ifdef WDOG_WINDOW_EN
                A_WINDOW: begin
                    if (r_unlocked) begin
                        r_window   <= w_wdata_cnt;
                        r_unlocked <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Watchdog sequencer: state, down-counter, prescaler, reset-pulse timer and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_ctrl     <= '0;
            r_count    <= '0;
            r_presc    <= '0;
            r_rst_cnt  <= '0;
            r_fired    <= 1'b0;
            r_irq      <= 1'b0;
            r_rst_out  <= 1'b0;
            r_timer_en <= 1'b0;
        end else begin
            if (w_stat_clr) begin
                r_fired <= 1'b0;
            end
            if (w_ctrl_acc) begin
                r_ctrl <= s_bus.wdata[1:0];
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_ctrl_acc && s_bus.wdata[0]) begin
                        r_state    <= ST_RUN;
                        r_count    <= r_load;
                        r_presc    <= '0;
                        r_timer_en <= 1'b1;
                    end
                end
                ST_RUN, ST_WARN: begin
                    if (w_ctrl_acc && !s_bus.wdata[0]) begin
                        // Disabled: stop with COUNT frozen.
                        r_state    <= ST_IDLE;
                        r_irq      <= 1'b0;
                        r_timer_en <= 1'b0;
                    end else if (w_fire) begin
                        r_state    <= ST_FIRE;
                        r_rst_out  <= 1'b1;
                        r_rst_cnt  <= RW'(RST_PULSE_LEN - 1);
                        r_fired    <= 1'b1;
                        r_ctrl[0]  <= 1'b0;
                        r_irq      <= 1'b0;
                        r_timer_en <= 1'b0;
                    end else if (w_kick) begin
                        r_state <= ST_RUN;
                        r_count <= r_load;
                        r_presc <= '0;
                        r_irq   <= 1'b0;
                    end else begin
                        r_count <= w_cnt_nxt;
                        r_presc <= w_presc_nxt;
                        if (w_cnt_nxt <= r_warn) begin
                            r_state <= ST_WARN;
                            r_irq   <= w_irq_en_nxt;
                        end else begin
                            r_state <= ST_RUN;
                            r_irq   <= 1'b0;
                        end
                    end
                end
                ST_FIRE: begin
                    if (r_rst_cnt == '0) begin
                        r_state   <= ST_IDLE;
                        r_rst_out <= 1'b0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt - RW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_wdog_irq = r_irq;
    assign o_wdog_rst = r_rst_out;
    assign o_timer_en = r_timer_en;

endmodule
